riscv_fetch_unit: RTL

RISCV_FETCH_UNIT -- requirements
Module: riscv_fetch_unit

---
 rtl/riscv_fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: credit-limited request issue, in-order response
// buffering tagged with the issuing PC, and redirect flush of stale responses.
module riscv_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] CREDIT = (CW+1)'(DEPTH);

    typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW-1:0] tw_q, tw_d, tr_q, tr_d;

    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] tag_mem  [DEPTH];

    logic req_fire, rsp_take, push, pop, tag_push;

    // Issue only while buffered plus in-flight words leave room for every response.
    assign imem_req_valid = !reset && (state_q == FETCH) &&
                            (({1'b0, count_q} + {1'b0, outst_q}) < CREDIT);
    assign imem_req_addr  = fetch_pc_q;
    assign inst_valid     = !reset && (count_q != '0);
    assign instruction    = inst_valid ? data_mem[rptr_q] : '0;
    assign inst_pc        = inst_valid ? pc_mem[rptr_q]   : '0;

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && (outst_q != '0);
    assign push     = rsp_take && (state_q == FETCH) && !redirect_valid;
    assign pop      = inst_valid && inst_ready && !redirect_valid;
    assign tag_push = req_fire && !redirect_valid;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        outst_d    = outst_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        tw_d       = tw_q;
        tr_d       = tr_q;

        case ({req_fire, rsp_take})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: ;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase

        if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
        if (push) begin
            wptr_d = wptr_q + 1'b1;
            tr_d   = tr_q + 1'b1;
        end
        if (pop)      rptr_d = rptr_q + 1'b1;
        if (tag_push) tw_d   = tw_q + 1'b1;

        if (state_q == FLUSH && rsp_take) begin
            discard_d = discard_q - 1'b1;
            if (discard_q == CW'(1)) state_d = FETCH;
        end

        // Everything still in flight after this edge, including a request
        // accepted right now, belongs to the old stream.
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFC;
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            tw_d       = '0;
            tr_d       = '0;
            discard_d  = outst_d;
            state_d    = (outst_d != '0) ? FLUSH : FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            tw_q       <= '0;
            tr_q       <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            tw_q       <= tw_d;
            tr_q       <= tr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && tag_push) tag_mem[tw_q] <= fetch_pc_q;
        if (!reset && push) begin
            data_mem[wptr_q] <= imem_rsp_data;
            pc_mem[wptr_q]   <= tag_mem[tr_q];
        end
    end
endmodule
